pc_fetch: RTL
=============

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles to wait for an instruction-memory response.
REQ-003 Reset is asynchronous and active-low; the block uses one clock.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 pc_in  input  32  next PC from the upstream next-PC mux; sampled only at instruction retire.
REQ-007 pc_out  output  32  current PC register, fed back to the next-PC mux.
REQ-008 pc_plus4  output  32  pc_out + 4, feeds the sequential/branch adder.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address.
REQ-011 imem_gnt  input  1  memory accepts the request this cycle.
REQ-012 imem_rvalid  input  1  read data valid.
REQ-013 imem_rdata  input  32  instruction word.
REQ-014 instr  output  32  fetched instruction, registered.
REQ-015 instr_valid  output  1  instr holds a valid instruction for the current PC.
REQ-016 instr_ready  input  1  downstream retires the instruction this cycle.
REQ-017 fetch_err  output  1  sticky error: misaligned PC or memory timeout.

Function
REQ-018 FSM states SHALL be FETCH, WAIT, HOLD, ERR; the state after reset SHALL be FETCH.
REQ-019 In FETCH, imem_req=1 and imem_addr=pc_out; on imem_gnt=1 -> WAIT.
REQ-020 imem_addr SHALL stay stable while imem_req=1 and gnt=0; the request SHALL NOT be withdrawn before gnt.
REQ-021 In WAIT, imem_req=0; on imem_rvalid=1, instr<=imem_rdata and the FSM -> HOLD.
REQ-022 imem_rvalid SHALL be ignored outside WAIT, including in the same cycle as gnt in FETCH.
REQ-023 In HOLD, instr_valid=1 and instr is stable; on instr_ready=1, pc_out<=pc_in and the FSM -> FETCH.
REQ-024 instr_valid SHALL be 1 only in HOLD.
REQ-025 Minimum latency: with gnt in the first FETCH cycle and rvalid on the next cycle, instr_valid SHALL rise 2 cycles after FETCH entry.
REQ-026 Minimum throughput: one instruction per 3 cycles.
REQ-027 pc_out SHALL change only on retire (HOLD and instr_ready) or on reset.
REQ-028 pc_plus4 SHALL be combinational and wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-029 Misaligned PC: if pc_in[1:0]!=0 at retire, pc_out SHALL still load pc_in, the FSM -> ERR, and fetch_err=1.
REQ-030 Timeout: a cycle counter SHALL clear on WAIT entry; after TIMEOUT WAIT cycles without rvalid, the FSM -> ERR and fetch_err=1.
REQ-031 ERR SHALL be absorbing until reset: imem_req=0, instr_valid=0, fetch_err=1.
REQ-032 The counter SHALL saturate and SHALL NOT wrap.

Reset
REQ-033 On rst_n=0, immediately and asynchronously:
- pc_out=RESET_PC
- state=FETCH
- instr=0
- fetch_err=0
- timeout counter=0
REQ-034 Reset during WAIT SHALL discard the outstanding response; an rvalid arriving after reset deassertion while in FETCH SHALL be ignored.
REQ-035 The first request after reset SHALL be issued in the first cycle with rst_n=1.

Structure
REQ-036 Shared package pc_fetch_pkg SHALL hold:
- FSM state encoding
- default RESET_PC
- default TIMEOUT
- instruction width constant (32)
REQ-037 One sub-module, pc_reg, SHALL be used: a 32-bit register with asynchronous active-low reset to RESET_PC and a load enable.

Verification
REQ-038 Reset release, gnt and rvalid immediate, rdata=32'h0000_0013, instr_ready=1, pc_in=pc_plus4 -> imem_addr sequence 0, 4, 8; instr_valid every 3rd cycle.
REQ-039 gnt delayed 3 cycles -> imem_req held high with imem_addr constant for 4 cycles; no instr_valid during that time.
REQ-040 instr_ready held 0 for 5 cycles in HOLD -> instr and pc_out unchanged; no new imem_req.
REQ-041 pc_in=32'h0000_0102 at retire -> pc_out=32'h0000_0102; fetch_err=1 next cycle; imem_req stays 0 thereafter.
REQ-042 No rvalid for 255 cycles in WAIT -> fetch_err=1; an rvalid on cycle 256 is ignored.
REQ-043 rst_n asserted mid-WAIT, then rvalid after release -> pc_out=RESET_PC; instr_valid stays 0 until a fresh gnt/rvalid pair.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared constants for the instruction fetch stage: FSM encoding, defaults, widths.
package pc_fetch_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_W    = 32;
   localparam int unsigned STATE_W = 2;

   localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int unsigned     DEFAULT_TIMEOUT  = 255;

   localparam logic [STATE_W-1:0] ST_FETCH = 2'd0;
   localparam logic [STATE_W-1:0] ST_WAIT  = 2'd1;
   localparam logic [STATE_W-1:0] ST_HOLD  = 2'd2;
   localparam logic [STATE_W-1:0] ST_ERR   = 2'd3;

endpackage

// File: rtl/pc_fetch_pc_reg.sv
// Program counter register: async active-low reset to RESET_PC, loads on enable.
module pc_reg
   import pc_fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [PC_W-1:0] d,
   output logic [PC_W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RESET_PC;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pc_fetch.sv
// Single-outstanding instruction fetch: request, wait for data, hold until retire.
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned     TIMEOUT  = DEFAULT_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PC_W-1:0]    pc_in,
   output logic [PC_W-1:0]    pc_out,
   output logic [PC_W-1:0]    pc_plus4,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic               fetch_err
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [INSTR_W-1:0] instr_q;
   logic               err_q;
   logic               instr_ld;
   logic               pc_ld;

   pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (pc_ld),
      .d     (pc_in),
      .q     (pc_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         cnt_q   <= '0;
         instr_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (instr_ld) begin
            instr_q <= imem_rdata;
         end
         err_q <= err_q | (state_d == ST_ERR);
      end
   end

   // Next state; rvalid only matters in WAIT, the wait counter saturates.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      instr_ld = 1'b0;
      pc_ld    = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (imem_gnt) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               state_d  = ST_HOLD;
               instr_ld = 1'b1;
            end else if (cnt_q >= CNT_LAST) begin
               state_d = ST_ERR;
            end else begin
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (instr_ready) begin
               pc_ld   = 1'b1;
               state_d = (pc_in[1:0] != 2'b00) ? ST_ERR : ST_FETCH;
            end
         end
         default: begin
            state_d = ST_ERR;
         end
      endcase
   end

   assign pc_plus4    = pc_out + PC_W'(4);
   assign imem_req    = (state_q == ST_FETCH);
   assign imem_addr   = pc_out;
   assign instr       = instr_q;
   assign instr_valid = (state_q == ST_HOLD);
   assign fetch_err   = err_q;

endmodule
